// File: rtl/lcm_capture_eg9013f_nz_pkg.sv
// Shared types and helpers for the EG9013F-NZ panel-bus capture block.
package lcm_capture_eg9013f_nz_pkg;

  localparam int BYTE_WIDTH         = 8;
  localparam int C_S_AXI_DATA_WIDTH = 32;
  localparam int BYTES_PER_WORD     = C_S_AXI_DATA_WIDTH / BYTE_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_CAPTURE    = 2'd2
  } cap_state_e;

  function automatic logic [7:0] bit_rev8(input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // Lane enables for a partial word holding n bytes in the low lanes
  function automatic logic [3:0] lane_mask(input logic [1:0] n);
    logic [3:0] m;
    case (n)
      2'd1:    m = 4'b0001;
      2'd2:    m = 4'b0011;
      2'd3:    m = 4'b0111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lcm_capture_eg9013f_nz_sync.sv
// Synchronises the asynchronous panel bus and turns xscl/lcm_lp into single-cycle events.
module lcm_capture_eg9013f_nz_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       xscl,
  input  logic       lcm_lp,
  input  logic       lcm_din,
  input  logic [7:0] lcm_data,
  output logic       xscl_fall,
  output logic       lp_rise,
  output logic       din_s,
  output logic [7:0] data_s
);

  logic [10:0] sync_r [SYNC_STAGES];
  logic [10:0] prev_r;

  // Bus bits as {data, din, lp, xscl}; din/data are re-registered so they align with the edge pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= 11'd0;
      prev_r    <= 11'd0;
      xscl_fall <= 1'b0;
      lp_rise   <= 1'b0;
      din_s     <= 1'b0;
      data_s    <= 8'h00;
    end else begin
      sync_r[0] <= {lcm_data, lcm_din, lcm_lp, xscl};
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
      prev_r    <= sync_r[SYNC_STAGES-1];
      xscl_fall <= prev_r[0] & ~sync_r[SYNC_STAGES-1][0];
      lp_rise   <= ~prev_r[1] & sync_r[SYNC_STAGES-1][1];
      din_s     <= sync_r[SYNC_STAGES-1][2];
      data_s    <= sync_r[SYNC_STAGES-1][10:3];
    end
  end

endmodule

// File: rtl/lcm_capture_eg9013f_nz.sv
// EG9013F-NZ panel-bus receiver: rebuilds 1-bpp frames from the bus and writes them as 32-bit words.
module lcm_capture_eg9013f_nz #(
  parameter int LCM_WIDTH_BITS  = 640,
  parameter int LCM_HEIGHT_BITS = 480,
  parameter int SYNC_STAGES     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        capture_en,
  input  logic        byte_order,
  input  logic        err_clear,
  input  logic        lcm_din,
  input  logic        lcm_lp,
  input  logic        xscl,
  input  logic [7:0]  lcm_data,
  output logic        ram_wen,
  output logic [31:0] ram_waddr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_wstrb,
  output logic        busy,
  output logic        frame_done,
  output logic [31:0] frame_count,
  output logic        err_line_len,
  output logic        err_frame_len
);
  import lcm_capture_eg9013f_nz_pkg::*;

  localparam int LINE_BYTES  = LCM_WIDTH_BITS / BYTE_WIDTH;
  localparam int LINE_WORDS  = LINE_BYTES / BYTES_PER_WORD;
  localparam int FRAME_WORDS = LINE_WORDS * LCM_HEIGHT_BITS;
  localparam int BCNT_W      = $clog2(LINE_BYTES + 1);
  localparam int LCNT_W      = $clog2(LCM_HEIGHT_BITS);
  localparam int ADDR_W      = $clog2(FRAME_WORDS);

  localparam logic [BCNT_W-1:0] FULL_LINE = BCNT_W'(LINE_BYTES);
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(LINE_BYTES - 1);
  localparam logic [LCNT_W-1:0] LAST_LINE = LCNT_W'(LCM_HEIGHT_BITS - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(LINE_WORDS);

  logic              xscl_fall, lp_rise, din_s;
  logic [7:0]        data_s, byte_s;
  cap_state_e        state_r;
  logic [BCNT_W-1:0] byte_cnt_r;
  logic [LCNT_W-1:0] line_cnt_r;
  logic [ADDR_W-1:0] line_base_r, word_addr_s;
  logic [31:0]       pack_r;

  lcm_capture_eg9013f_nz_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .xscl      (xscl),
    .lcm_lp    (lcm_lp),
    .lcm_din   (lcm_din),
    .lcm_data  (lcm_data),
    .xscl_fall (xscl_fall),
    .lp_rise   (lp_rise),
    .din_s     (din_s),
    .data_s    (data_s)
  );

  // Byte as it lands in the word, and the word the current byte belongs to
  always_comb begin
    byte_s      = byte_order ? bit_rev8(data_s) : data_s;
    word_addr_s = line_base_r + ADDR_W'(byte_cnt_r[BCNT_W-1:2]);
  end

  // Capture FSM with counters, packing, write strobes and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      byte_cnt_r    <= '0;
      line_cnt_r    <= '0;
      line_base_r   <= '0;
      pack_r        <= 32'h0;
      ram_wen       <= 1'b0;
      ram_waddr     <= 32'h0;
      ram_wdata     <= 32'h0;
      ram_wstrb     <= 4'h0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      frame_count   <= 32'h0;
      err_line_len  <= 1'b0;
      err_frame_len <= 1'b0;
    end else begin
      ram_wen    <= 1'b0;
      ram_wstrb  <= 4'h0;
      frame_done <= 1'b0;
      // Clear first so an error raised in this same cycle overrides it
      if (err_clear) begin
        err_line_len  <= 1'b0;
        err_frame_len <= 1'b0;
      end
      if (!capture_en) begin
        state_r    <= ST_IDLE;
        busy       <= 1'b0;
        pack_r     <= 32'h0;
        byte_cnt_r <= '0;
      end else begin
        case (state_r)
          ST_IDLE: state_r <= ST_WAIT_FRAME;
          ST_WAIT_FRAME: begin
            if (lp_rise && din_s) begin
              state_r     <= ST_CAPTURE;
              busy        <= 1'b1;
              byte_cnt_r  <= '0;
              line_cnt_r  <= '0;
              line_base_r <= '0;
              pack_r      <= 32'h0;
            end
          end
          ST_CAPTURE: begin
            if (lp_rise) begin
              if (byte_cnt_r[1:0] != 2'd0) begin
                ram_wen   <= 1'b1;
                ram_waddr <= 32'(word_addr_s);
                ram_wdata <= pack_r;
                ram_wstrb <= lane_mask(byte_cnt_r[1:0]);
              end
              pack_r     <= 32'h0;
              byte_cnt_r <= '0;
              if (din_s) begin
                err_frame_len <= 1'b1;
                line_cnt_r    <= '0;
                line_base_r   <= '0;
              end else begin
                if (byte_cnt_r != FULL_LINE) err_line_len <= 1'b1;
                if (line_cnt_r != LAST_LINE) begin
                  line_cnt_r  <= line_cnt_r + 1'b1;
                  line_base_r <= line_base_r + LINE_STEP;
                end
              end
            end else if (xscl_fall) begin
              if (byte_cnt_r >= FULL_LINE) begin
                err_line_len <= 1'b1;
              end else begin
                byte_cnt_r <= byte_cnt_r + 1'b1;
                if (byte_cnt_r[1:0] == 2'd3) begin
                  ram_wen   <= 1'b1;
                  ram_waddr <= 32'(word_addr_s);
                  ram_wdata <= {byte_s, pack_r[23:0]};
                  ram_wstrb <= 4'hF;
                  pack_r    <= 32'h0;
                  if (byte_cnt_r == LAST_BYTE && line_cnt_r == LAST_LINE) begin
                    frame_done  <= 1'b1;
                    frame_count <= frame_count + 32'd1;
                    state_r     <= ST_WAIT_FRAME;
                    busy        <= 1'b0;
                  end
                end else begin
                  pack_r[{byte_cnt_r[1:0], 3'b000} +: 8] <= byte_s;
                end
              end
            end
          end
          default: begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcm_capture_eg9013f_nz.sv
// Directed bench for lcm_capture_eg9013f_nz; frame height reduced to 120 lines to keep the full-frame run short.
module tb_lcm_capture_eg9013f_nz;

  localparam int H  = 120;
  localparam int FW = 20 * H;

  logic        clk = 1'b0;
  logic        rst_n, capture_en, byte_order, err_clear;
  logic        lcm_din, lcm_lp, xscl;
  logic [7:0]  lcm_data;
  logic        ram_wen, busy, frame_done, err_line_len, err_frame_len;
  logic [31:0] ram_waddr, ram_wdata, frame_count;
  logic [3:0]  ram_wstrb;

  int          n_vec = 0, n_err = 0;
  int          wr_cnt = 0, fd_cnt = 0, exp_addr = 0, w0;
  logic [31:0] last_addr = 32'h0, last_data = 32'h0;
  logic [3:0]  last_strb = 4'h0;
  logic        fd_with_wen = 1'b0, seq_on = 1'b0;

  always #5 clk = ~clk;

  lcm_capture_eg9013f_nz #(.LCM_WIDTH_BITS(640), .LCM_HEIGHT_BITS(H), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .capture_en(capture_en), .byte_order(byte_order),
    .err_clear(err_clear), .lcm_din(lcm_din), .lcm_lp(lcm_lp), .xscl(xscl),
    .lcm_data(lcm_data), .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_wstrb(ram_wstrb), .busy(busy), .frame_done(frame_done), .frame_count(frame_count),
    .err_line_len(err_line_len), .err_frame_len(err_frame_len)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] seq_word(input int a);
    int b;
    b = 4 * a;
    return {8'(b + 3), 8'(b + 2), 8'(b + 1), 8'(b)};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    lcm_data = b;
    xscl = 1'b1;
    tick(2);
    xscl = 1'b0;
    tick(2);
  endtask

  task automatic lp(input logic din);
    lcm_din = din;
    tick(2);
    lcm_lp = 1'b1;
    tick(2);
    lcm_lp = 1'b0;
    tick(2);
    lcm_din = 1'b0;
  endtask

  task automatic clear_err();
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
  endtask

  // Write monitor: logs every strobe and checks the running address/data during the full-frame run
  always @(negedge clk) begin
    if (!seq_on) exp_addr = 0;
    if (ram_wen) begin
      wr_cnt++;
      last_addr = ram_waddr;
      last_data = ram_wdata;
      last_strb = ram_wstrb;
      if (seq_on) begin
        check_eq("seq_addr", ram_waddr, 32'(exp_addr));
        check_eq("seq_data", ram_wdata, seq_word(exp_addr));
        exp_addr++;
      end
    end
    if (frame_done) begin
      fd_cnt++;
      fd_with_wen = ram_wen;
    end
  end

  initial begin
    rst_n = 1'b0; capture_en = 1'b0; byte_order = 1'b0; err_clear = 1'b0;
    lcm_din = 1'b0; lcm_lp = 1'b0; xscl = 1'b0; lcm_data = 8'h00;
    tick(3);
    check_eq("rst_wen", 32'(ram_wen), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_fcount", frame_count, 32'd0);
    check_eq("rst_err", 32'({err_line_len, err_frame_len}), 32'd0);
    rst_n = 1'b1;
    tick(2);
    capture_en = 1'b1;
    tick(2);

    // 1: stray bus activity before a frame start, then one complete frame
    send_byte(8'h55); send_byte(8'h66); lp(1'b0); tick(8);
    check_eq("wait_no_wr", 32'(wr_cnt), 32'd0);
    check_eq("wait_busy", 32'(busy), 32'd0);
    seq_on = 1'b1;
    lp(1'b1);
    check_eq("cap_busy", 32'(busy), 32'd1);
    for (int ln = 0; ln < H; ln++) begin
      for (int b = 0; b < 80; b++) send_byte(8'(ln * 80 + b));
      if (ln < H - 1) lp(1'b0);
    end
    tick(8);
    seq_on = 1'b0;
    check_eq("frame_writes", 32'(wr_cnt), 32'(FW));
    check_eq("frame_last_addr", last_addr, 32'(FW - 1));
    check_eq("frame_done_cnt", 32'(fd_cnt), 32'd1);
    check_eq("frame_done_wen", 32'(fd_with_wen), 32'd1);
    check_eq("frame_count1", frame_count, 32'd1);
    check_eq("frame_err", 32'({err_line_len, err_frame_len}), 32'd0);
    check_eq("frame_idle_busy", 32'(busy), 32'd0);

    // 2: bit-reversed bytes, then normal order from the next byte
    byte_order = 1'b1;
    lp(1'b1);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04); tick(8);
    check_eq("rev_data", last_data, 32'h20C04080);
    check_eq("rev_addr", last_addr, 32'd0);
    check_eq("rev_strb", 32'(last_strb), 32'hF);
    byte_order = 1'b0;
    send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h08); tick(8);
    check_eq("fwd_data", last_data, 32'h08070605);
    check_eq("fwd_addr", last_addr, 32'd1);

    // Frame start inside a frame flags an error; err_clear drops it
    lp(1'b1); tick(4);
    check_eq("restart_err", 32'(err_frame_len), 32'd1);
    clear_err(); tick(1);
    check_eq("clear_err", 32'({err_line_len, err_frame_len}), 32'd0);

    // 3: short line 5, then over-long line 6
    for (int ln = 0; ln < 5; ln++) begin
      for (int b = 0; b < 80; b++) send_byte(8'(b));
      lp(1'b0);
    end
    tick(4);
    check_eq("full_lines_err", 32'(err_line_len), 32'd0);
    for (int b = 0; b < 78; b++) send_byte(8'(b));
    lp(1'b0); tick(4);
    check_eq("short_addr", last_addr, 32'd119);
    check_eq("short_strb", 32'(last_strb), 32'h3);
    check_eq("short_data", last_data, 32'h00004D4C);
    check_eq("short_err", 32'(err_line_len), 32'd1);
    send_byte(8'hA0); send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); tick(8);
    check_eq("line6_addr", last_addr, 32'd120);
    check_eq("line6_data", last_data, 32'hA3A2A1A0);
    clear_err();
    w0 = wr_cnt;
    for (int b = 4; b < 81; b++) send_byte(8'(b));
    tick(8);
    check_eq("long_writes", 32'(wr_cnt - w0), 32'd19);
    check_eq("long_last_addr", last_addr, 32'd139);
    check_eq("long_err", 32'(err_line_len), 32'd1);

    // 4: frame start during line 100 with a partial word pending
    lp(1'b1);
    clear_err();
    for (int i = 0; i < 100; i++) lp(1'b0);
    for (int b = 0; b < 6; b++) send_byte(8'(8'h11 + b));
    tick(8);
    check_eq("l100_addr", last_addr, 32'd2000);
    check_eq("l100_data", last_data, 32'h14131211);
    check_eq("l100_noerr", 32'(err_frame_len), 32'd0);
    lp(1'b1); tick(4);
    check_eq("flush_addr", last_addr, 32'd2001);
    check_eq("flush_strb", 32'(last_strb), 32'h3);
    check_eq("flush_data", last_data, 32'h00001615);
    check_eq("frame_err_set", 32'(err_frame_len), 32'd1);
    check_eq("frame_count_keep", frame_count, 32'd1);
    send_byte(8'h21); send_byte(8'h22); send_byte(8'h23); send_byte(8'h24); tick(8);
    check_eq("restart_addr", last_addr, 32'd0);
    check_eq("restart_data", last_data, 32'h24232221);

    // 5: capture_en dropped mid-line, then re-armed without a frame start
    send_byte(8'h31); send_byte(8'h32); tick(8);
    w0 = wr_cnt;
    capture_en = 1'b0;
    tick(2);
    check_eq("dis_busy", 32'(busy), 32'd0);
    for (int b = 0; b < 4; b++) send_byte(8'(b));
    tick(8);
    check_eq("dis_no_wr", 32'(wr_cnt), 32'(w0));
    capture_en = 1'b1;
    tick(2);
    lp(1'b0);
    for (int b = 0; b < 4; b++) send_byte(8'(b));
    tick(8);
    check_eq("rearm_no_wr", 32'(wr_cnt), 32'(w0));
    check_eq("rearm_busy", 32'(busy), 32'd0);

    // 6: asynchronous reset in the middle of a frame
    lp(1'b1);
    send_byte(8'h41); send_byte(8'h42); send_byte(8'h43); send_byte(8'h44); tick(8);
    check_eq("pre_rst_data", last_data, 32'h44434241);
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    send_byte(8'h45);
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_fcount", frame_count, 32'd0);
    check_eq("arst_err", 32'({err_line_len, err_frame_len}), 32'd0);
    check_eq("arst_wdata", ram_wdata, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    w0 = wr_cnt;
    for (int b = 0; b < 4; b++) send_byte(8'(b));
    lp(1'b0);
    for (int b = 0; b < 4; b++) send_byte(8'(b));
    tick(8);
    check_eq("post_rst_no_wr", 32'(wr_cnt), 32'(w0));
    lp(1'b1);
    send_byte(8'h51); send_byte(8'h52); send_byte(8'h53); send_byte(8'h54); tick(8);
    check_eq("post_rst_wr", 32'(wr_cnt), 32'(w0 + 1));
    check_eq("post_rst_addr", last_addr, 32'd0);
    check_eq("post_rst_data", last_data, 32'h54535251);
    check_eq("post_rst_err", 32'({err_line_len, err_frame_len}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
